// File: rtl/lcd_pkg.sv
// Shared LCD definitions: arbiter state encoding, command/data flag values
// and default timing shared with the display sequencer.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } lcd_arb_state_t;

    localparam logic CMD  = 1'b0;
    localparam logic DATA = 1'b1;

    localparam int HOLDOFF_US_DEF = 50;
    localparam int TIMEOUT_US_DEF = 5000;

endpackage

// File: rtl/lcd_req_slot.sv
// One-entry request slot: captures a byte-write pulse, holds it until the
// arbiter finishes that byte, and flags requests dropped while full.
module lcd_req_slot
    import lcd_pkg::*;
(
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       set_ena,
    input  logic [7:0] set_data,
    input  logic       set_cmd_data,
    input  logic       clr,
    output logic       pending,
    output logic [7:0] data,
    output logic       cmd_data,
    output logic       ovf
);

    logic capture;

    // A new request is accepted when empty, or on the very edge the slot drains
    assign capture = set_ena && (!pending || clr);

    // Pending flag and sticky overflow; a set on the clearing edge wins over the clear
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            ovf     <= 1'b0;
        end else if (capture) begin
            pending <= 1'b1;
        end else if (set_ena) begin
            ovf     <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

    // Byte storage; contents only matter while pending, so no reset is needed
    always_ff @(posedge clk_1MHz) begin
        if (capture) begin
            data     <= set_data;
            cmd_data <= set_cmd_data;
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing the single LCD byte writer between the display
// sequencer (requester 0) and a secondary source (requester 1). Enforces a
// settle gap after every byte and a bounded wait for the writer's done pulse.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int HOLDOFF_US = HOLDOFF_US_DEF,
    parameter int TIMEOUT_US = TIMEOUT_US_DEF,
    parameter int CNT_W      = 13
)
(
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       req0_ena,
    input  logic [7:0] req0_data,
    input  logic       req0_cmd_data,
    output logic       req0_done,
    input  logic       req1_ena,
    input  logic [7:0] req1_data,
    input  logic       req1_cmd_data,
    output logic       req1_done,
    output logic [7:0] wr_data,
    output logic       wr_cmd_data,
    output logic       wr_ena,
    input  logic       wr_done,
    output logic       busy,
    output logic       grant,
    output logic [1:0] ovf,
    output logic       timeout_err
);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_US - 1);

    lcd_arb_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend;
    logic [1:0]       clr;
    logic [7:0]       slot0_data, slot1_data;
    logic             slot0_cmd, slot1_cmd;
    logic             winner;
    logic             grant_d;
    logic             wr_load;
    logic             done_fire;
    logic             timeout_hit;
    logic [7:0]       sel_data;
    logic             sel_cmd;

    lcd_req_slot u_slot0 (
        .clk_1MHz     (clk_1MHz),
        .rst_n        (rst_n),
        .set_ena      (req0_ena),
        .set_data     (req0_data),
        .set_cmd_data (req0_cmd_data),
        .clr          (clr[0]),
        .pending      (pend[0]),
        .data         (slot0_data),
        .cmd_data     (slot0_cmd),
        .ovf          (ovf[0])
    );

    lcd_req_slot u_slot1 (
        .clk_1MHz     (clk_1MHz),
        .rst_n        (rst_n),
        .set_ena      (req1_ena),
        .set_data     (req1_data),
        .set_cmd_data (req1_cmd_data),
        .clr          (clr[1]),
        .pending      (pend[1]),
        .data         (slot1_data),
        .cmd_data     (slot1_cmd),
        .ovf          (ovf[1])
    );

    assign busy = (state_q != ST_IDLE);

    // Next-state, counter, arbitration and slot-clear decisions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        grant_d     = grant;
        wr_load     = 1'b0;
        done_fire   = 1'b0;
        timeout_hit = 1'b0;
        // On a tie the requester not served last wins; otherwise the only pending one
        winner      = (pend[0] && pend[1]) ? ~grant : pend[1];
        sel_data    = winner ? slot1_data : slot0_data;
        sel_cmd     = winner ? slot1_cmd  : slot0_cmd;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (|pend) begin
                    grant_d = winner;
                    wr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A real done on the timeout edge counts as a normal completion
                if (wr_done) begin
                    done_fire = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    done_fire   = 1'b1;
                    timeout_hit = 1'b1;
                end
                if (done_fire) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        clr = done_fire ? (grant ? 2'b10 : 2'b01) : 2'b00;
    end

    // State, counter, writer handshake and per-requester done pulses
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant       <= 1'b1;
            wr_ena      <= 1'b0;
            wr_data     <= 8'h00;
            wr_cmd_data <= 1'b0;
            req0_done   <= 1'b0;
            req1_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant     <= grant_d;
            wr_ena    <= wr_load;
            req0_done <= clr[0];
            req1_done <= clr[1];
            if (wr_load) begin
                wr_data     <= sel_data;
                wr_cmd_data <= sel_cmd;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
